// File: rtl/op_share_arbiter_pkg.sv
// Shared types and helpers for blocks that time-share one dataflow operator
// between several requesting graph nodes.
package op_share_arbiter_pkg;

  localparam int MAX_M  = 16;
  localparam int MAX_TW = 4;

  typedef struct packed {
    logic              any;
    logic [MAX_TW-1:0] g;
  } pick_t;

  function automatic int tag_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic [MAX_M-1:0] onehot(input logic [MAX_TW-1:0] tag);
    logic [MAX_M-1:0] v;
    v      = '0;
    v[tag] = 1'b1;
    return v;
  endfunction

  // First requester at or after ptr, wrapping modulo m.
  function automatic pick_t rr_pick(input logic [MAX_M-1:0] req,
                                    input logic [MAX_TW-1:0] ptr,
                                    input int m);
    pick_t p;
    int    idx;
    p.any = 1'b0;
    p.g   = ptr;
    for (int k = 0; k < MAX_M; k++) begin
      if (k < m) begin
        idx = (int'(ptr) + k) % m;
        if (!p.any && req[idx]) begin
          p.any = 1'b1;
          p.g   = idx[MAX_TW-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/op_share_arbiter_if.sv
// Requester and operator token buses of the operator-sharing arbiter.
interface op_share_arbiter_if #(
  parameter int N = 16,
  parameter int M = 4
);
  logic           EN;
  logic [M-1:0]   REQ_R;
  logic [M*N-1:0] REQ_D;
  logic [M-1:0]   REQ_ACK;
  logic           OP_EN;
  logic           OP_R_IN;
  logic [N-1:0]   OP_D_IN;
  logic           OP_R_OUT;
  logic [N-1:0]   OP_D_OUT;
  logic [M-1:0]   RES_R;
  logic [N-1:0]   RES_D;
  logic           BUSY;
  logic           ERR;

  modport slave (
    input  EN, REQ_R, REQ_D, OP_R_OUT, OP_D_OUT,
    output REQ_ACK, OP_EN, OP_R_IN, OP_D_IN, RES_R, RES_D, BUSY, ERR
  );

  modport master (
    output EN, REQ_R, REQ_D, OP_R_OUT, OP_D_OUT,
    input  REQ_ACK, OP_EN, OP_R_IN, OP_D_IN, RES_R, RES_D, BUSY, ERR
  );
endinterface

// File: rtl/op_share_arbiter_rr_grant.sv
// Combinational round-robin picker: one-hot grant and its index, starting at ptr.
module op_share_arbiter_rr_grant
  import op_share_arbiter_pkg::*;
#(
  parameter int M  = 4,
  parameter int TW = 2
) (
  input  logic [M-1:0]  req,
  input  logic [TW-1:0] ptr,
  output logic [M-1:0]  gnt,
  output logic [TW-1:0] g,
  output logic          any
);

  logic [MAX_M-1:0]  req_ext;
  logic [MAX_M-1:0]  oh;
  logic [MAX_TW-1:0] ptr_ext;
  pick_t             pick;
  logic              unused_bits;

  always_comb begin
    req_ext          = '0;
    req_ext[M-1:0]   = req;
    ptr_ext          = '0;
    ptr_ext[TW-1:0]  = ptr;
    pick             = rr_pick(req_ext, ptr_ext, M);
    oh               = onehot(pick.g);
    any              = pick.any;
    g                = pick.g[TW-1:0];
    gnt              = pick.any ? oh[M-1:0] : '0;
  end

  assign unused_bits = ^{oh, pick.g};

endmodule

// File: rtl/op_share_arbiter.sv
// Round-robin sharing of one fixed-latency operator between M requesters; each issued
// token is tagged so the operator result can be routed back to its originator.
module op_share_arbiter
  import op_share_arbiter_pkg::*;
#(
  parameter int N   = 16,
  parameter int M   = 4,
  parameter int LAT = 1
) (
  input logic              CLK,
  input logic              RST,
  op_share_arbiter_if.slave bus
);

  localparam int TW = tag_width(M);
  localparam int CW = $clog2(LAT + 1);

  logic [TW-1:0] ptr;
  logic [M-1:0]  gnt;
  logic [TW-1:0] g;
  logic          any;
  logic          grant;
  logic [TW-1:0] sel;
  logic          vld_p [LAT];
  logic [TW-1:0] tag_p [LAT];
  logic [M-1:0]  res_r;
  logic          res_any;
  logic [CW-1:0] count;
  logic          err;

  op_share_arbiter_rr_grant #(.M(M), .TW(TW)) u_rr_grant (
    .req (bus.REQ_R),
    .ptr (ptr),
    .gnt (gnt),
    .g   (g),
    .any (any)
  );

  // A token acked while RST is high would be lost, so reset suppresses the grant.
  assign grant       = bus.EN & any & ~RST;
  assign sel         = grant ? g : ptr;
  assign bus.REQ_ACK = grant ? gnt : '0;
  assign bus.OP_EN   = bus.EN;
  assign bus.OP_R_IN = grant;
  assign bus.OP_D_IN = bus.REQ_D[int'(sel)*N +: N];

  always_ff @(posedge CLK) begin
    if (RST)
      ptr <= '0;
    else if (grant)
      ptr <= (int'(g) == M - 1) ? '0 : g + 1'b1;
  end

  // Tag pipe stage 0 .. LAT-1, aligned with the operator's internal stages
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < LAT; s++) vld_p[s] <= 1'b0;
    end else if (bus.EN) begin
      vld_p[0] <= grant;
      for (int s = 1; s < LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (bus.EN) begin
      tag_p[0] <= g;
      for (int s = 1; s < LAT; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  // Result routing from the last tag stage
  always_comb begin
    res_r = '0;
    if (bus.EN && !RST && bus.OP_R_OUT && vld_p[LAT-1]) begin
      for (int i = 0; i < M; i++) res_r[i] = (int'(tag_p[LAT-1]) == i);
    end
  end

  assign res_any   = |res_r;
  assign bus.RES_R = res_r;
  assign bus.RES_D = bus.OP_D_OUT;

  always_ff @(posedge CLK) begin
    if (RST)
      count <= '0;
    else if (grant && !res_any)
      count <= count + 1'b1;
    else if (!grant && res_any)
      count <= count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      err <= 1'b0;
    else if (bus.EN && (bus.OP_R_OUT != vld_p[LAT-1]))
      err <= 1'b1;
  end

  assign bus.BUSY = (count != '0);
  assign bus.ERR  = err;

endmodule

// File: tb/tb_op_share_arbiter.sv
// Drives two arbiter instances (LAT=1 and LAT=3) with shared stimulus and checks
// each against a token-queue reference model plus a behavioural operator.
module tb_op_share_arbiter;

  localparam int N = 16;
  localparam int M = 4;

  typedef struct {
    int          port;
    int          due;
    logic [15:0] res;
  } tok_t;

  logic           clk;
  logic           rst;
  logic           en;
  logic [M-1:0]   req_r;
  logic [M*N-1:0] req_d;
  logic           inject;
  logic           chk_en;
  int             checks;
  int             failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] op_f(input logic [15:0] d);
    return (d > 16'd5) ? 16'd1 : 16'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : 3;

    op_share_arbiter_if #(.N(N), .M(M)) bus ();

    op_share_arbiter #(.N(N), .M(M), .LAT(L)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
    );

    logic        opv [L];
    logic [15:0] opd [L];

    assign bus.EN       = en;
    assign bus.REQ_R    = req_r;
    assign bus.REQ_D    = req_d;
    assign bus.OP_R_OUT = opv[L-1] | inject;
    assign bus.OP_D_OUT = opd[L-1];

    always @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < L; s++) begin
          opv[s] <= 1'b0;
          opd[s] <= '0;
        end
      end else if (bus.OP_EN) begin
        opv[0] <= bus.OP_R_IN;
        opd[0] <= op_f(bus.OP_D_IN);
        for (int s = 1; s < L; s++) begin
          opv[s] <= opv[s-1];
          opd[s] <= opd[s-1];
        end
      end
    end

    tok_t     q[$];
    int       ptr_m = 0;
    int       ecnt  = 0;
    logic     err_m = 1'b0;
    int       g_m;
    int       idx;
    bit       due_m;
    logic [M-1:0] exp_ack;
    logic [M-1:0] exp_res;
    logic [15:0]  gd;

    always @(negedge clk) begin
      if (chk_en) begin
        g_m = -1;
        if (en && !rst) begin
          for (int j = 0; j < M; j++) begin
            idx = (ptr_m + j) % M;
            if (g_m < 0 && req_r[idx]) g_m = idx;
          end
        end
        due_m   = (q.size() != 0) && (q[0].due == ecnt);
        exp_ack = (g_m >= 0) ? (4'b0001 << g_m) : 4'b0000;
        exp_res = (en && !rst && due_m) ? (4'b0001 << q[0].port) : 4'b0000;

        chk($sformatf("L%0d req_ack", L), 64'(bus.REQ_ACK), 64'(exp_ack));
        chk($sformatf("L%0d op_r_in", L), 64'(bus.OP_R_IN), 64'(g_m >= 0));
        chk($sformatf("L%0d op_en", L), 64'(bus.OP_EN), 64'(en));
        if (g_m >= 0) begin
          gd = req_d[g_m*N +: N];
          chk($sformatf("L%0d op_d_in", L), 64'(bus.OP_D_IN), 64'(gd));
        end
        chk($sformatf("L%0d res_r", L), 64'(bus.RES_R), 64'(exp_res));
        if (exp_res != 0)
          chk($sformatf("L%0d res_d", L), 64'(bus.RES_D), 64'(q[0].res));
        chk($sformatf("L%0d busy", L), 64'(bus.BUSY), 64'(q.size() != 0));
        chk($sformatf("L%0d err", L), 64'(bus.ERR), 64'(err_m));

        if (rst) begin
          q.delete();
          ptr_m = 0;
          ecnt  = 0;
          err_m = 1'b0;
        end else if (en) begin
          if (inject && !due_m) err_m = 1'b1;
          if (due_m) void'(q.pop_front());
          if (g_m >= 0) begin
            q.push_back('{port: g_m, due: ecnt + L, res: op_f(req_d[g_m*N +: N])});
            ptr_m = (g_m + 1) % M;
          end
          ecnt++;
        end
      end
    end
  end

  task automatic step(input logic e, input logic [M-1:0] r);
    en    = e;
    req_r = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, '0);
    rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < M; i++) req_d[i*N +: N] = 16'($urandom_range(0, 11));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    en       = 1'b0;
    req_r    = '0;
    req_d    = '0;
    inject   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Idle after reset
    idle(2);

    // Single token from port 2, operand 7
    req_d[2*N +: N] = 16'h0007;
    step(1'b1, 4'b0100);
    idle(4);

    // All ports requesting from ptr=0
    do_reset();
    rand_data();
    for (int i = 0; i < 8; i++) step(1'b1, 4'b1111);
    idle(4);

    // Freeze while a token is in flight
    do_reset();
    step(1'b1, 4'b0100);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111);
    step(1'b1, 4'b0010);
    idle(4);

    // Reset right after a grant
    step(1'b1, 4'b0100);
    do_reset();
    idle(4);

    // Single requester back-to-back
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step(1'b1, 4'b1000);
    end
    idle(4);

    // Spurious operator result with an empty tag pipe
    inject = 1'b1;
    step(1'b1, '0);
    inject = 1'b0;
    idle(3);
    do_reset();
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_data();
      rst    = ($urandom_range(0, 99) == 0);
      inject = ($urandom_range(0, 149) == 0);
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
    end
    rst    = 1'b0;
    inject = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
